// File: rtl/uart_receiver.sv
// uart_receiver: oversampled UART receiver recovering 8N1 frames (LSB first) from an
// asynchronous rxd line using a shared x16 baud strobe.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit between the data
// and stop bits. Without it, frames are plain 8N1 and parity_err is tied low.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   rxd        in   asynchronous serial input, idle high
//   baud_x16   in   oversample strobe (rising edge detected internally)
//   rx_data    out  last good byte, updates only with rx_valid
//   rx_valid   out  one-cycle pulse, rx_data holds a new byte
//   rx_busy    out  high while a frame is in progress (state != IDLE)
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   parity_err out  one-cycle pulse alongside rx_valid on parity mismatch
module uart_receiver #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 baud_x16,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int unsigned TW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = $clog2(DATA_BITS);
    localparam int unsigned MID = OVERSAMPLE / 2;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY    = 3'd3;
`endif
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;
    logic                   rxd_prev_q;
    logic                   baud_d_q;
    logic                   tick;

    logic [2:0]           state_q,    state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q,    shreg_d;
    logic [1:0]           samp_q,     samp_d;
    logic [DATA_BITS-1:0] rx_data_q,  rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q;

    logic maj;
    logic resolve;
    logic wrap;
    logic active;

`ifdef UART_RX_PARITY_EN
    logic par_bad_q,    par_bad_d;
    logic parity_err_q, parity_err_d;
`endif

    assign rxd_s = sync_q[SYNC_STAGES-1];
    assign tick  = baud_x16 & ~baud_d_q;

    // Only counting states sample the line; WAIT_HIGH just watches the level.
    assign active  = (state_q != S_IDLE) && (state_q != S_WAIT_HIGH);
    assign resolve = tick && active && (tick_cnt_q == TW'(MID + 1));
    assign wrap    = tick && active && (tick_cnt_q == TW'(OVERSAMPLE - 1));

    // 2-of-3 vote over the samples at MID-1, MID and the live value at MID+1.
    assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        samp_d      = samp_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        if (tick && active) begin
            tick_cnt_d = wrap ? '0 : tick_cnt_q + TW'(1);
            if (tick_cnt_q == TW'(MID - 1)) samp_d[0] = rxd_s;
            if (tick_cnt_q == TW'(MID))     samp_d[1] = rxd_s;
        end

        case (state_q)
            S_IDLE: begin
                if (rxd_prev_q && !rxd_s) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            S_START: begin
                // A start bit that votes high was a glitch: drop it silently.
                if (resolve && maj) begin
                    state_d = S_IDLE;
                end else if (wrap) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (resolve) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                if (wrap) begin
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (resolve) par_bad_d = (^shreg_q) ^ maj;
                if (wrap)    state_d   = S_STOP;
            end
`endif
            S_STOP: begin
                // Leave half a bit early so a back-to-back start edge is caught.
                if (resolve) begin
                    if (maj) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = par_bad_q;
`endif
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // Held-low line (break) must not look like a fresh start edge.
                if (rxd_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Synchronizer, edge detectors and FSM registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '1;
            rxd_prev_q  <= 1'b1;
            baud_d_q    <= 1'b0;
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            samp_q      <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], rxd};
            rxd_prev_q  <= rxd_s;
            baud_d_q    <= baud_x16;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            samp_q      <= samp_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= (state_d != S_IDLE);
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames driven into uart_receiver with expected results
// worked out by hand; a negedge monitor counts output pulses and records bytes.
module tb_uart_receiver;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic       baud_x16;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;

    int n_cmp = 0;
    int n_mis = 0;

    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         perr_cnt  = 0;
    logic [7:0] got_q[$];

    uart_receiver dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .baud_x16   (baud_x16),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt <= valid_cnt + 1;
            got_q.push_back(rx_data);
        end
        if (frame_err)  ferr_cnt <= ferr_cnt + 1;
        if (parity_err) perr_cnt <= perr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One baud_x16 tick: high for two clocks so the edge detect is exercised.
    task automatic tick();
        baud_x16 = 1'b1;
        repeat (2) @(negedge clk);
        baud_x16 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (16) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par) begin end
`endif
        send_bit(stop_b);
    endtask

    task automatic idle_ticks(input int n);
        rxd = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        int vbase;
        int fbase;

        rst      = 1'b1;
        rxd      = 1'b1;
        baud_x16 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_valid",  32'(rx_valid),   32'h0);
        check("rst_ferr",   32'(frame_err),  32'h0);
        check("rst_perr",   32'(parity_err), 32'h0);
        check("rst_busy",   32'(rx_busy),    32'h0);
        check("rst_data",   32'(rx_data),    32'h0);

        // T1: single good frame
        idle_ticks(4);
        vbase = valid_cnt; fbase = ferr_cnt;
        send_frame(8'h55, 1'b0, 1'b1);
        idle_ticks(4);
        check("t1_valid_cnt", 32'(valid_cnt - vbase), 32'd1);
        check("t1_data",      32'(got_q[vbase]),      32'h55);
        check("t1_ferr",      32'(ferr_cnt - fbase),  32'd0);
        check("t1_busy",      32'(rx_busy),           32'h0);

        // T2: back-to-back frames with a stop bit of exactly one bit time
        vbase = valid_cnt; fbase = ferr_cnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b1);
        idle_ticks(4);
        check("t2_valid_cnt", 32'(valid_cnt - vbase), 32'd2);
        check("t2_data0",     32'(got_q[vbase]),      32'hA5);
        check("t2_data1",     32'(got_q[vbase + 1]),  32'h3C);
        check("t2_ferr",      32'(ferr_cnt - fbase),  32'd0);

        // T3: short low glitch rejected at the start-bit vote
        vbase = valid_cnt; fbase = ferr_cnt;
        rxd = 1'b0;
        repeat (4) tick();
        check("t3_busy_glitch", 32'(rx_busy), 32'h1);
        idle_ticks(16);
        check("t3_busy_after", 32'(rx_busy),           32'h0);
        check("t3_valid_cnt",  32'(valid_cnt - vbase), 32'd0);
        check("t3_ferr",       32'(ferr_cnt - fbase),  32'd0);

        // T4: stop bit low, line held low as a break
        vbase = valid_cnt; fbase = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(i == 0 || i == 7);
`ifdef UART_RX_PARITY_EN
        send_bit(1'b0);
`endif
        rxd = 1'b0;
        repeat (40) tick();
        check("t4_ferr_cnt",  32'(ferr_cnt - fbase),  32'd1);
        check("t4_valid_cnt", 32'(valid_cnt - vbase), 32'd0);
        check("t4_data_kept", 32'(rx_data),           32'h3C);
        check("t4_busy_low",  32'(rx_busy),           32'h1);
        idle_ticks(4);
        check("t4_busy_high", 32'(rx_busy),           32'h0);

        // T5: reset in the middle of a frame, then a clean frame
        vbase = valid_cnt; fbase = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        rxd = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_rst_data", 32'(rx_data), 32'h0);
        check("t5_rst_busy", 32'(rx_busy), 32'h0);
        idle_ticks(4);
        send_frame(8'h0F, 1'b0, 1'b1);
        idle_ticks(4);
        check("t5_valid_cnt", 32'(valid_cnt - vbase), 32'd1);
        check("t5_data",      32'(got_q[vbase]),      32'h0F);
        check("t5_ferr",      32'(ferr_cnt - fbase),  32'd0);

`ifdef UART_RX_PARITY_EN
        // T6: 0x07 has three ones, so even parity needs a 1
        vbase = valid_cnt;
        fbase = perr_cnt;
        send_frame(8'h07, 1'b0, 1'b1);
        idle_ticks(4);
        check("t6_bad_valid", 32'(valid_cnt - vbase), 32'd1);
        check("t6_bad_data",  32'(got_q[vbase]),      32'h07);
        check("t6_bad_perr",  32'(perr_cnt - fbase),  32'd1);
        vbase = valid_cnt;
        fbase = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        idle_ticks(4);
        check("t6_ok_valid", 32'(valid_cnt - vbase), 32'd1);
        check("t6_ok_perr",  32'(perr_cnt - fbase),  32'd0);
`else
        check("perr_never", 32'(perr_cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
